// File: rtl/hlsm_arbiter.sv
// Round-robin owner of one shared HLSM: grants a requester, pulses Start, waits for Done (or watchdog),
// then Acks. Grant 1 cycle after Req is sampled in IDLE; requesters hold Req until Ack (no other backpressure).
module hlsm_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 13,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_REQ-1:0] Req,
    output logic [NUM_REQ-1:0] Ack,
    output logic [NUM_REQ-1:0] Grant,
    output logic               Start,
    input  logic               Done,
    output logic               Busy,
    output logic               LatErr,
    output logic               TimeoutErr,
    output logic [CNTW-1:0]    JobCount,
    output logic [CNTW-1:0]    LastLatency
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ACK} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_gidx;
    logic [CNTW-1:0]     r_cnt;

    logic                w_any;
    logic [PW-1:0]       w_sel;
    logic [PW-1:0]       w_idx;
    logic [NUM_REQ-1:0]  w_grant;
    int                  w_j;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        w_j   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            w_idx = PW'(w_j);
            if (!w_any && Req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    assign w_grant = NUM_REQ'(1) << w_sel;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_cnt       <= '0;
            Ack         <= '0;
            Grant       <= '0;
            Start       <= 1'b0;
            Busy        <= 1'b0;
            LatErr      <= 1'b0;
            TimeoutErr  <= 1'b0;
            JobCount    <= '0;
            LastLatency <= '0;
        end else begin
            Start <= 1'b0;
            Ack   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (Done) LatErr <= 1'b1;
                    if (w_any) begin
                        Grant   <= w_grant;
                        r_gidx  <= w_sel;
                        Start   <= 1'b1;
                        Busy    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (Done) LatErr <= 1'b1;
                    r_cnt   <= CNTW'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A Done landing exactly on the watchdog limit still counts as a real completion.
                    if (Done) begin
                        LastLatency <= r_cnt;
                        if (r_cnt != CNTW'(LATENCY)) LatErr <= 1'b1;
                        JobCount <= JobCount + 1'b1;
                        Ack      <= Grant;
                        Grant    <= '0;
                        r_state  <= S_ACK;
                    end else if (r_cnt == CNTW'(TIMEOUT)) begin
                        TimeoutErr  <= 1'b1;
                        LastLatency <= r_cnt;
                        JobCount    <= JobCount + 1'b1;
                        Ack         <= Grant;
                        Grant       <= '0;
                        r_state     <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (Done) LatErr <= 1'b1;
                    r_ptr   <= (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_arbiter.sv
// Bench for hlsm_arbiter: job table driven through a Start/Done responder, expectations queued at Start
// and compared when Ack appears, plus hand-written spurious-Done and mid-job reset sequences.
module tb_hlsm_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 13;
    localparam int TIMEOUT = 64;
    localparam int CNTW    = 16;

    logic               Clk = 1'b0;
    logic               Rst;
    logic [NUM_REQ-1:0] Req;
    logic [NUM_REQ-1:0] Ack;
    logic [NUM_REQ-1:0] Grant;
    logic               Start;
    logic               Done;
    logic               Busy;
    logic               LatErr;
    logic               TimeoutErr;
    logic [CNTW-1:0]    JobCount;
    logic [CNTW-1:0]    LastLatency;

    hlsm_arbiter #(
        .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Ack(Ack), .Grant(Grant), .Start(Start),
        .Done(Done), .Busy(Busy), .LatErr(LatErr), .TimeoutErr(TimeoutErr),
        .JobCount(JobCount), .LastLatency(LastLatency)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit       rst_before;
        bit [3:0] req;
        int       delay;      // 0 = Done never returned
        bit [3:0] grant;
        bit       gap;        // check Start spacing against the previous job
    } vec_t;

    typedef struct {
        bit [3:0]  ack;
        bit [15:0] lat;
        bit [15:0] jobs;
        bit        laterr;
        bit        toerr;
        int        ack_cyc;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_start = 0;
    int last_lat   = 0;
    int m_jobs = 0;
    bit m_laterr = 0;
    bit m_toerr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_jobs = 0;
        m_laterr = 0;
        m_toerr = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        Req = '0;
        Done = 1'b0;
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        model_reset();
        step();
    endtask

    task automatic check_ack();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_ack actual=%0h expected=none", Ack);
            return;
        end
        e = sb.pop_front();
        chk("ack", Ack, e.ack);
        chk("ack_cycle", cyc, e.ack_cyc);
        chk("last_latency", LastLatency, e.lat);
        chk("job_count", JobCount, e.jobs);
        chk("lat_err", LatErr, e.laterr);
        chk("timeout_err", TimeoutErr, e.toerr);
        chk("grant_in_ack", Grant, 0);
        chk("busy_in_ack", Busy, 1);
    endtask

    task automatic run_job(input vec_t v);
        int  c0;
        int  lat;
        bit  tmo;
        bit  got;
        exp_t e;
        if (v.rst_before) do_reset();
        Req = v.req;
        c0 = cyc;
        step();
        chk("start", Start, 1);
        chk("grant", Grant, v.grant);
        chk("busy", Busy, 1);
        if (v.gap) chk("start_gap", cyc - last_start, last_lat + 3);
        last_start = cyc;
        tmo = (v.delay == 0) || (v.delay > TIMEOUT);
        lat = tmo ? TIMEOUT : v.delay;
        m_jobs++;
        if (!tmo && v.delay != LATENCY) m_laterr = 1;
        if (tmo) m_toerr = 1;
        e.ack = v.grant;
        e.lat = 16'(lat);
        e.jobs = 16'(m_jobs);
        e.laterr = m_laterr;
        e.toerr = m_toerr;
        e.ack_cyc = c0 + 2 + lat;
        sb.push_back(e);
        last_lat = lat;
        got = 0;
        for (int k = 1; k <= TIMEOUT + 10 && !got; k++) begin
            Done = !tmo && (k == 1 + v.delay);
            step();
            Done = 1'b0;
            if (Ack != '0) begin
                got = 1;
                check_ack();
            end else begin
                chk("start_low_in_wait", Start, 0);
            end
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL ack_missing actual=none expected=%0h", v.grant);
        end
        Req = '0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        vec_t v;
        Rst = 1'b0;
        Req = '0;
        Done = 1'b0;

        // Fairness from reset pointer, each requester absent for the IDLE cycle after its Ack
        tbl[0]  = '{0, 4'b1111, 13, 4'b0001, 0};
        tbl[1]  = '{0, 4'b1110, 13, 4'b0010, 1};
        tbl[2]  = '{0, 4'b1101, 13, 4'b0100, 1};
        tbl[3]  = '{0, 4'b1011, 13, 4'b1000, 1};
        tbl[4]  = '{0, 4'b0111, 13, 4'b0001, 1};
        tbl[5]  = '{0, 4'b0010, 13, 4'b0010, 1};
        tbl[6]  = '{0, 4'b0100, 10, 4'b0100, 1};
        tbl[7]  = '{0, 4'b0001, 13, 4'b0001, 1};
        // Watchdog then a normal job with pointer wrap (ptr=3 -> requester 1)
        tbl[8]  = '{1, 4'b0100, 0,  4'b0100, 0};
        tbl[9]  = '{0, 4'b0010, 13, 4'b0010, 1};
        // Done exactly at the watchdog limit, then wrap to requester 0
        tbl[10] = '{1, 4'b1000, 64, 4'b1000, 0};
        tbl[11] = '{0, 4'b0101, 13, 4'b0001, 1};

        step();
        step();
        chk("rst_ack", Ack, 0);
        chk("rst_grant", Grant, 0);
        chk("rst_start", Start, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_laterr", LatErr, 0);
        chk("rst_toerr", TimeoutErr, 0);
        chk("rst_jobs", JobCount, 0);
        chk("rst_lastlat", LastLatency, 0);
        Rst = 1'b1;
        step();

        for (int i = 0; i < 12; i++) run_job(tbl[i]);

        // Spurious Done in IDLE
        do_reset();
        Done = 1'b1;
        step();
        Done = 1'b0;
        chk("spurious_laterr", LatErr, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("spurious_no_start", Start, 0);
            chk("spurious_no_ack", Ack, 0);
        end
        chk("spurious_jobs", JobCount, 0);
        chk("spurious_busy", Busy, 0);

        // Reset mid-WAIT with pointer moved off requester 0
        do_reset();
        v = '{0, 4'b0010, 13, 4'b0010, 0};
        run_job(v);
        Req = 4'b0010;
        step();
        chk("mid_start", Start, 1);
        for (int i = 0; i < 5; i++) step();
        chk("mid_grant_before", Grant, 4'b0010);
        #2;
        Rst = 1'b0;
        Req = '0;
        #1;
        chk("mid_rst_grant", Grant, 0);
        chk("mid_rst_ack", Ack, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_start", Start, 0);
        chk("mid_rst_jobs", JobCount, 0);
        chk("mid_rst_lastlat", LastLatency, 0);
        model_reset();
        step();
        Rst = 1'b1;
        step();
        chk("post_rst_no_ack", Ack, 0);
        v = '{0, 4'b1001, 13, 4'b0001, 0};
        run_job(v);
        v = '{0, 4'b1000, 13, 4'b1000, 1};
        run_job(v);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/hlsm_arbiter.md
# hlsm_arbiter

Round-robin arbiter and sequencer that shares one HLSM datapath instance among NUM_REQ requesters using the HLSM Start/Done handshake. It grants one requester at a time and pulses Start. It then waits for Done, measures the Start-to-Done latency against the expected LATENCY, and acknowledges the granted requester. A watchdog recovers from a hung datapath. Operand and result muxing sits outside this block and is steered by Grant.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LATENCY, 13, expected Start-to-Done cycle count of the shared HLSM
- TIMEOUT, 64, watchdog limit in cycles after Start (TIMEOUT > LATENCY, TIMEOUT < 2^CNTW)
- CNTW, 16, width of the latency and job counters

- Clk  in  1  clock, all registers on rising edge
- Rst  in  1  asynchronous, active-low reset
- Req  in  NUM_REQ  per-requester job request, held until its Ack
- Ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- Grant  out  NUM_REQ  one-hot owner of the HLSM, held from LAUNCH through WAIT
- Start  out  1  one-cycle start pulse to the HLSM
- Done  in  1  HLSM completion pulse
- Busy  out  1  high in LAUNCH, WAIT and ACK
- LatErr  out  1  sticky: latency mismatch or spurious Done
- TimeoutErr  out  1  sticky: watchdog expired
- JobCount  out  CNTW  completed jobs (including timed-out jobs), wraps modulo 2^CNTW
- LastLatency  out  CNTW  latency measured for the most recent job

## Operation
- Reset (Rst low, asynchronous): state IDLE. Ack, Grant, Start, Busy, LatErr, TimeoutErr, JobCount and LastLatency all clear to 0. The internal cycle counter clears to 0. The RR pointer resets so that Req[0] has highest priority.
- IDLE: if any Req bit is high, select the first set bit scanning from the pointer upward with wrap. Register Grant as one-hot and go to LAUNCH. If no Req bit is high, stay in IDLE.
- LAUNCH (1 cycle): Start=1 and the cycle counter is set to 0. Go to WAIT.
- WAIT: the counter increments by 1 every cycle, so the first WAIT cycle has count 1.
  - Done high with count=L: LastLatency<=L, LatErr set if L≠LATENCY, JobCount++. Go to ACK.
  - Done low with count=TIMEOUT: TimeoutErr set, LastLatency<=TIMEOUT, JobCount++. Go to ACK.
  - Done high with count=TIMEOUT is a normal completion, not a timeout.
- ACK (1 cycle): Grant=0, Ack[g]=1 for the granted index g. The pointer becomes g+1 (mod NUM_REQ). Go to IDLE.
- Done high in IDLE, LAUNCH or ACK sets LatErr and has no other effect.
- Requester rules:
  - A requester drops Req at the edge ending its Ack cycle; the following IDLE cycle samples the dropped Req.
  - Req dropped while that requester is granted is ignored: the job runs to completion and Ack still pulses.
  - Req bits of non-granted requesters may change at any time.
- Changes to the Req vector are sampled only in IDLE.
- Sticky flags clear only on reset.

## Timing
- Req first high in IDLE cycle 0 leads to:
  - Grant and Start high in cycle 1;
  - Done expected in cycle 1+LATENCY;
  - Ack in cycle 2+LATENCY.
- Back-to-back Start pulses are spaced L+3 cycles apart (L = actual latency). With LATENCY=13 the spacing is 16 cycles.
- Start is never high outside LAUNCH. Grant is never multi-hot. Ack is never high for a non-granted index.
- Reset asserted mid-job clears everything immediately, including an in-flight Grant or Ack. No Ack is issued for the aborted job.

## Test plan
- Single request, defaults: Req=4'b0010 held, Done returned 13 cycles after Start.
  - Expect Grant=0010 and Start in cycle 1, Ack=0010 in cycle 15.
  - Expect LastLatency=13, JobCount=1, LatErr=0.
- Fairness: Req=4'b1111 held continuously, each requester dropping Req for one cycle after its Ack.
  - Expect grant order 0,1,2,3,0 with Start pulses 16 cycles apart.
- Latency mismatch: Done returned after 10 cycles.
  - Expect LastLatency=10, LatErr=1, Ack delivered normally.
  - A following job with 13-cycle latency leaves LatErr at 1.
- Watchdog: Done never asserted.
  - Expect TimeoutErr=1 in the cycle after count reaches 64, Ack pulse, LastLatency=64, JobCount=1.
  - The next job runs normally.
- Spurious Done pulsed in IDLE with Req=0.
  - Expect LatErr=1, no Start, no Ack, JobCount unchanged.
- Reset mid-WAIT: Rst driven low 5 cycles after Start.
  - Expect all outputs 0 immediately, pointer back to requester 0, no Ack.
  - After release, Req=4'b1000 is granted in the cycle after IDLE samples it.
